// File: rtl/jogo_pkg.sv
// Shared definitions for the parametrised memory-sequence game:
// FSM state codes, one-hot check and the default sequence table.
package jogo_pkg;

  typedef enum logic [4:0] {
    INICIAL     = 5'd0,
    PREPARA     = 5'd1,
    MOSTRA      = 5'd2,
    ESPERA      = 5'd3,
    REGISTRA    = 5'd4,
    COMPARA     = 5'd5,
    SOLTA       = 5'd6,
    SOLTA_FIM   = 5'd7,
    ESCREVE     = 5'd8,
    SOLTA_ESC   = 5'd9,
    PROX_RODADA = 5'd10,
    FIM_GANHOU  = 5'd11,
    FIM_PERDEU  = 5'd12,
    FIM_TIMEOUT = 5'd13
  } estado_t;

  localparam int N_SEQ_BASE = 16;

  // Bit index (0..3) of each default entry, 2 bits per entry, entry 0 in the LSBs.
  localparam logic [31:0] SEQ_BASE = 32'h4FA506E4;

  function automatic logic eh_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  function automatic int bit_padrao(input int idx, input int n_botoes);
    return int'(SEQ_BASE[2*(idx % N_SEQ_BASE) +: 2]) % n_botoes;
  endfunction

endpackage

// File: rtl/memoria_sequencia.sv
// Sequence memory: N_RODADAS one-hot entries, parallel load from the
// default table, one synchronous write port and one asynchronous read port.
module memoria_sequencia
  import jogo_pkg::*;
#(
  parameter int N_BOTOES  = 4,
  parameter int N_RODADAS = 16
) (
  input  logic                         clock,
  input  logic                         i_carrega,
  input  logic                         i_escreve,
  input  logic [$clog2(N_RODADAS)-1:0] i_end_escrita,
  input  logic [N_BOTOES-1:0]          i_dado,
  input  logic [$clog2(N_RODADAS)-1:0] i_end_leitura,
  output logic [N_BOTOES-1:0]          o_dado
);

  logic [N_BOTOES-1:0] r_mem [N_RODADAS];

  always_ff @(posedge clock) begin
    if (i_carrega) begin
      for (int i = 0; i < N_RODADAS; i++) begin
        r_mem[i] <= N_BOTOES'(1) << bit_padrao(i, N_BOTOES);
      end
    end else if (i_escreve) begin
      r_mem[i_end_escrita] <= i_dado;
    end
  end

  assign o_dado = r_mem[i_end_leitura];

endmodule

// File: rtl/jogo_sequencia_param.sv
// Memory-sequence game core: shows one LED per round, checks the replay,
// optionally lets the player append an entry, ends in win/loss/timeout.
module jogo_sequencia_param
  import jogo_pkg::*;
#(
  parameter int N_BOTOES       = 4,
  parameter int N_RODADAS      = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int LED_CICLOS     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         jogar,
  input  logic                         modo,
  input  logic [N_BOTOES-1:0]          botoes,
  output logic [N_BOTOES-1:0]          leds,
  output logic                         pronto,
  output logic                         ganhou,
  output logic                         perdeu,
  output logic                         timeout,
  output logic [4:0]                   db_estado,
  output logic [$clog2(N_RODADAS)-1:0] db_rodada,
  output logic [$clog2(N_RODADAS)-1:0] db_jogada
);

  localparam int RW = $clog2(N_RODADAS);
  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam int LW = $clog2(LED_CICLOS + 1);

  estado_t             r_estado, w_prox;
  logic                r_modo;
  logic [RW-1:0]       r_rodada, r_jogada;
  logic [N_BOTOES-1:0] r_captura;
  logic [TW-1:0]       r_cnt_to;
  logic [LW-1:0]       r_cnt_led;
  logic                r_pronto, r_ganhou, r_perdeu, r_timeout;

  logic [N_BOTOES-1:0] w_mem_dado;
  logic [RW-1:0]       w_end_leitura;
  logic                w_carrega, w_escreve;
  logic                w_press_oh, w_capt_oh, w_solto, w_led_fim, w_to_fim;
  logic                w_pronto, w_ganhou, w_perdeu, w_timeout;

  assign w_press_oh    = eh_one_hot(32'(botoes));
  assign w_capt_oh     = eh_one_hot(32'(r_captura));
  assign w_solto       = (botoes == '0);
  assign w_led_fim     = (r_cnt_led == LW'(LED_CICLOS - 1));
  assign w_to_fim      = (r_cnt_to == TW'(TIMEOUT_CICLOS - 1));
  assign w_end_leitura = (r_estado == MOSTRA) ? r_rodada : r_jogada;
  assign w_carrega     = (r_estado == PREPARA);
  assign w_escreve     = (r_estado == ESCREVE) && w_press_oh;

  memoria_sequencia #(
    .N_BOTOES  (N_BOTOES),
    .N_RODADAS (N_RODADAS)
  ) u_mem (
    .clock         (clock),
    .i_carrega     (w_carrega),
    .i_escreve     (w_escreve),
    .i_end_escrita (r_rodada + RW'(1)),
    .i_dado        (botoes),
    .i_end_leitura (w_end_leitura),
    .o_dado        (w_mem_dado)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= INICIAL;
    else       r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL:     if (jogar) w_prox = PREPARA;
      PREPARA:     w_prox = MOSTRA;
      MOSTRA:      if (w_led_fim) w_prox = ESPERA;
      ESPERA: begin
        // A press in the expiring cycle still counts as a press.
        if (!w_solto)      w_prox = REGISTRA;
        else if (w_to_fim) w_prox = FIM_TIMEOUT;
      end
      REGISTRA:    w_prox = COMPARA;
      COMPARA: begin
        if (!w_capt_oh || (r_captura != w_mem_dado)) w_prox = FIM_PERDEU;
        else if (r_jogada != r_rodada)               w_prox = SOLTA;
        else if (r_rodada == RW'(N_RODADAS - 1))     w_prox = FIM_GANHOU;
        else                                         w_prox = SOLTA_FIM;
      end
      SOLTA:       if (w_solto) w_prox = ESPERA;
      SOLTA_FIM:   if (w_solto) w_prox = r_modo ? ESCREVE : PROX_RODADA;
      ESCREVE: begin
        if (w_press_oh)    w_prox = SOLTA_ESC;
        else if (w_to_fim) w_prox = FIM_TIMEOUT;
      end
      SOLTA_ESC:   if (w_solto) w_prox = PROX_RODADA;
      PROX_RODADA: w_prox = MOSTRA;
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (jogar) w_prox = PREPARA;
      default:     w_prox = INICIAL;
    endcase
  end

  always_comb begin
    leds = '0;
    case (r_estado)
      MOSTRA:          leds = w_mem_dado;
      ESPERA, ESCREVE: leds = botoes;
      default:         leds = '0;
    endcase
    w_ganhou  = (w_prox == FIM_GANHOU);
    w_timeout = (w_prox == FIM_TIMEOUT);
    w_perdeu  = (w_prox == FIM_PERDEU) || w_timeout;
    w_pronto  = w_ganhou || w_perdeu;
  end

  // End flags are registered from the next state so they appear with the end state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_modo    <= 1'b0;
      r_rodada  <= '0;
      r_jogada  <= '0;
      r_captura <= '0;
      r_cnt_to  <= '0;
      r_cnt_led <= '0;
      r_pronto  <= 1'b0;
      r_ganhou  <= 1'b0;
      r_perdeu  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (r_estado == PREPARA) begin
        r_modo   <= modo;
        r_rodada <= '0;
        r_jogada <= '0;
      end
      if (r_estado == REGISTRA) r_captura <= botoes;
      if ((r_estado == COMPARA) && (w_prox == SOLTA)) r_jogada <= r_jogada + RW'(1);
      if (r_estado == PROX_RODADA) begin
        r_rodada <= r_rodada + RW'(1);
        r_jogada <= '0;
      end
      if ((r_estado == MOSTRA) && (w_prox == MOSTRA)) r_cnt_led <= r_cnt_led + LW'(1);
      else                                             r_cnt_led <= '0;
      if (((w_prox == ESPERA) || (w_prox == ESCREVE)) && (w_prox == r_estado))
        r_cnt_to <= r_cnt_to + TW'(1);
      else
        r_cnt_to <= '0;
      r_pronto  <= w_pronto;
      r_ganhou  <= w_ganhou;
      r_perdeu  <= w_perdeu;
      r_timeout <= w_timeout;
    end
  end

  assign pronto    = r_pronto;
  assign ganhou    = r_ganhou;
  assign perdeu    = r_perdeu;
  assign timeout   = r_timeout;
  assign db_estado = r_estado;
  assign db_rodada = r_rodada;
  assign db_jogada = r_jogada;

endmodule
